// File: rtl/seq_signed_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_signed_multiplier_if
//  Purpose  : Request/result bundle between a multiplier client and the
//             sequential signed/unsigned multiplier.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_signed_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    // Client side: issues operands, observes status and result
    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    // Multiplier side
    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/seq_signed_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_signed_multiplier
//  Purpose  : Radix-2 shift-add multiplier, one step per cycle. Signed
//             operands are reduced to magnitudes at capture and the result
//             is negated once at completion, so the datapath is unsigned.
//  Revision : 1.0  initial release
// ============================================================================
module seq_signed_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_signed_multiplier_if.slave bus
);
    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;        // |A|, shifted left each step
    logic [WIDTH-1:0]     b_q, b_d;        // |B|, shifted right each step
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;    // result must be negated at the end

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   acc_step;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which read as
    // unsigned is exactly its magnitude.
    always_comb begin
        mag_a = (bus.signed_mode && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand
                                                               : bus.multiplicand;
        mag_b = (bus.signed_mode && bus.multiplier[WIDTH-1])   ? -bus.multiplier
                                                               : bus.multiplier;
    end

    // Partial sum after the current step
    always_comb begin
        acc_step = acc_q + (b_q[0] ? a_q : '0);
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = {{WIDTH{1'b0}}, mag_a};
                    b_d     = mag_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = bus.signed_mode &
                              (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Last step: publish the finished sum directly, never a partial one
                if (cnt_q == c_LAST) begin
                    prod_d  = neg_q ? -acc_step : acc_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;

endmodule
`default_nettype wire

// File: doc/seq_signed_multiplier.md
SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand width in bits; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL have port signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled with start.
REQ-006 SHALL have port multiplicand  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port multiplier  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a multiplication is iterating (RUN state).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking that product has been updated.
REQ-010 SHALL have port product  output  2*WIDTH  registered result; two's complement when signed_mode was 1.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge E0, capture operands and mode, clear the accumulator and iteration counter, and enter RUN.
REQ-013 SHALL, on capture in signed mode, store operand magnitudes (|A|, |B| as unsigned WIDTH-bit values, so -2^(WIDTH-1) maps to 2^(WIDTH-1)) and a result-sign bit = A[MSB] XOR B[MSB]; in unsigned mode, store operands unchanged with sign bit 0.
REQ-014 SHALL, in RUN, perform one radix-2 shift-add step per cycle: add the shifted magnitude of A to the 2*WIDTH-bit accumulator when the current bit of B (LSB first) is 1.
REQ-015 SHALL leave RUN after exactly WIDTH steps, at edge E0+WIDTH; on that edge product SHALL load the accumulator, two's-complement negated if the sign bit is 1, and the FSM SHALL enter DONE.
REQ-016 SHALL assert done only in DONE, for exactly one cycle (between edges E0+WIDTH and E0+WIDTH+1), then return to IDLE unconditionally.
REQ-017 SHALL assert busy only in RUN (WIDTH cycles); busy and done SHALL never be high together.
REQ-018 SHALL ignore start while in RUN or DONE; no new capture, no effect on the result in progress.
REQ-019 SHALL accept start in the first IDLE cycle after DONE (back-to-back issue interval WIDTH+2 cycles).
REQ-020 SHALL hold product unchanged outside the completion edge; product never shows partial sums.
REQ-021 SHALL produce the exact product for all operands, including -2^(WIDTH-1) x -2^(WIDTH-1) = +2^(2*WIDTH-2), with no overflow or saturation.
REQ-022 SHALL treat a zero operand like any other (full WIDTH iterations, no early termination).

Reset
REQ-023 SHALL, while rst_n=0, immediately force state IDLE, busy=0, done=0, product=0, accumulator and counter=0, regardless of clk.
REQ-024 SHALL, on rst_n assertion mid-RUN or in DONE, discard the operation; no done pulse and no product update afterwards.
REQ-025 SHALL accept start at the first rising edge after rst_n deasserts.

Verification (WIDTH=4)
REQ-026 Unsigned: A=7, B=9, signed_mode=0, start one cycle -> busy high 4 cycles, then done one cycle, product=0x3F.
REQ-027 Unsigned max: A=15, B=15, signed_mode=0 -> product=0xE1 (225).
REQ-028 Signed mixed sign: A=-3 (0xD), B=5, signed_mode=1 -> product=0xF1 (-15); A=-8, B=-8 -> product=0x40 (+64).
REQ-029 Start during busy: issue 2x3, pulse start with 6x6 two cycles later -> single done, product=0x06; 6x6 not performed; next start after done accepted.
REQ-030 Reset mid-operation: start 5x5, drop rst_n at cycle 2 of RUN -> busy, done, product all 0 immediately; no done after release; new 3x3 then gives 0x09.
REQ-031 Random: 1000 random operand/mode pairs issued back-to-back -> every product matches reference model; done count equals start-accept count.
